// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor: instruction decode enum,
// opcode values, ALU operation codes and the opcode decode helper.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BNEG,
    I_BNNEG,
    I_BZERO,
    I_BNZERO,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BNEG   = 8'h02;
  localparam logic [7:0] OPC_BNNEG  = 8'h03;
  localparam logic [7:0] OPC_BZERO  = 8'h04;
  localparam logic [7:0] OPC_BNZERO = 8'h05;
  localparam logic [7:0] OPC_BOV    = 8'h06;
  localparam logic [7:0] OPC_BNOV   = 8'h07;
  localparam logic [7:0] OPC_HALT   = 8'h0F;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Unlisted opcodes fall back to NOP so the control unit never stalls on junk.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
    decoded_instruction_type d;
    case (opc)
      OPC_LOAD:   d = I_LOAD;
      OPC_STORE:  d = I_STORE;
      OPC_MOVE:   d = I_MOVE;
      OPC_ADD:    d = I_ADD;
      OPC_SUB:    d = I_SUB;
      OPC_AND:    d = I_AND;
      OPC_OR:     d = I_OR;
      OPC_BRANCH: d = I_BRANCH;
      OPC_BNEG:   d = I_BNEG;
      OPC_BNNEG:  d = I_BNNEG;
      OPC_BZERO:  d = I_BZERO;
      OPC_BNZERO: d = I_BNZERO;
      OPC_BOV:    d = I_BOV;
      OPC_BNOV:   d = I_BNOV;
      OPC_HALT:   d = I_HALT;
      default:    d = I_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational ALU of the K&S datapath: ADD/AND/OR/SUB plus MOVE pass-through,
// producing the result and the zero/negative/carry/signed-overflow flags.
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        operation,
  input  logic              is_move,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              carry,
  output logic              ovf
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit of diff is the borrow, set exactly when a < b unsigned.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    if (is_move) begin
      result = b;
    end else begin
      case (operation)
        ALU_ADD: begin
          result = sum[DATA_W-1:0];
          carry  = sum[DATA_W];
          ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        end
        ALU_SUB: begin
          result = diff[DATA_W-1:0];
          carry  = diff[DATA_W];
          ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        end
        ALU_AND: result = a & b;
        ALU_OR:  result = a | b;
        default: result = '0;
      endcase
    end
    zero = (result == '0);
    neg  = result[DATA_W-1];
  end

endmodule

// File: rtl/ks_datapath.sv
// K&S processor datapath: PC, IR, 4-entry register file, ALU and flag register.
// Optional KS_R0_ZERO_EN hardwires R0 to zero (writes dropped, reads return 0).
module ks_datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rf [4];

  logic [1:0]        mem_reg;
  logic [1:0]        dst_reg;
  logic [1:0]        src_a;
  logic [1:0]        src_b;
  logic [1:0]        wr_idx;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_neg;
  logic              alu_carry;
  logic              alu_ovf;
  logic              unused_ir_bit;

  assign mem_reg       = ir[6:5];
  assign dst_reg       = ir[5:4];
  assign src_a         = ir[3:2];
  assign src_b         = ir[1:0];
  assign unused_ir_bit = ir[7];

  assign decoded_instruction = decode_opcode(ir[15:8]);

  assign wr_idx  = c_sel ? mem_reg : dst_reg;
  assign wr_data = c_sel ? data_in : alu_result;

`ifdef KS_R0_ZERO_EN
  assign op_a     = (src_a == 2'd0) ? '0 : rf[src_a];
  assign op_b     = (src_b == 2'd0) ? '0 : rf[src_b];
  assign data_out = (mem_reg == 2'd0) ? '0 : rf[mem_reg];
  assign wr_ok    = (wr_idx != 2'd0);
`else
  assign op_a     = rf[src_a];
  assign op_b     = rf[src_b];
  assign data_out = rf[mem_reg];
  assign wr_ok    = 1'b1;
`endif

  assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;

  ks_alu #(.DATA_W(DATA_W)) u_alu (
    .operation (operation),
    .is_move   (decoded_instruction == I_MOVE),
    .a         (op_a),
    .b         (op_b),
    .result    (alu_result),
    .zero      (alu_zero),
    .neg       (alu_neg),
    .carry     (alu_carry),
    .ovf       (alu_ovf)
  );

  // PC branches to the IR value present before this edge, even if the IR
  // is being reloaded in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pc_enable) pc <= branch ? ir[ADDR_W-1:0] : pc + 1'b1;
      if (ir_enable) ir <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (write_reg_enable && wr_ok) begin
      rf[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= alu_zero;
      neg_op            <= alu_neg;
      unsigned_overflow <= alu_carry;
      signed_overflow   <= alu_ovf;
    end
  end

endmodule
